ew_ddr_sched: RTL and testbench

EW_DDR_SCHED -- requirements
Module: ew_ddr_sched

---
 rtl/ew_ddr_sched_pkg.sv | 47 ++++
 rtl/ew_desc_fifo.sv | 61 ++++++
 rtl/ew_ddr_sched.sv | 175 +++++++++++++++++
 tb/tb_ew_ddr_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ew_ddr_sched_pkg.sv
// ============================================================================
// Module : ew_ddr_sched_pkg
// Brief  : Shared widths, FSM state encodings and descriptor type for the
//          event-window DDR scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

// Defaults apply only when the tracker parameter header has not defined them.
`ifndef EVENT_SIZE_BITS
`define EVENT_SIZE_BITS 16
`endif
`ifndef SPILL_TAG_BITS
`define SPILL_TAG_BITS 20
`endif
`ifndef EW_SCHED_ST_IDLE
`define EW_SCHED_ST_IDLE    3'd0
`define EW_SCHED_ST_LOAD    3'd1
`define EW_SCHED_ST_START   3'd2
`define EW_SCHED_ST_WAIT    3'd3
`define EW_SCHED_ST_ADVANCE 3'd4
`endif

package ew_ddr_sched_pkg;

  localparam int c_size_bits = `EVENT_SIZE_BITS;
  localparam int c_tag_bits  = `SPILL_TAG_BITS;
  localparam int c_desc_bits = 1 + c_size_bits + c_tag_bits + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = `EW_SCHED_ST_IDLE,
    ST_LOAD    = `EW_SCHED_ST_LOAD,
    ST_START   = `EW_SCHED_ST_START,
    ST_WAIT    = `EW_SCHED_ST_WAIT,
    ST_ADVANCE = `EW_SCHED_ST_ADVANCE
  } sched_state_t;

  typedef struct packed {
    logic                   sel;
    logic [c_size_bits-1:0] size;
    logic [c_tag_bits-1:0]  tag;
    logic                   ovfl;
  } ew_desc_t;

endpackage

`default_nettype wire

// File: rtl/ew_desc_fifo.sv
// ============================================================================
// Module : ew_desc_fifo
// Brief  : Two-entry descriptor FIFO; one slot per EW_FIFO bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ew_desc_fifo
  import ew_ddr_sched_pkg::*;
(
  input  logic                   serdesclk,
  input  logic                   resetn_serdesclk,
  input  logic                   push,
  input  logic [c_desc_bits-1:0] push_data,
  input  logic                   pop,
  output logic [c_desc_bits-1:0] pop_data,
  output logic                   full,
  output logic                   empty
);

  logic [c_desc_bits-1:0] r_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  assign w_push_ok = push && (r_count != 2'd2);
  assign w_pop_ok  = pop  && (r_count != 2'd0);

  always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
    if (!resetn_serdesclk) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == 2'd2);
  assign empty    = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/ew_ddr_sched.sv
// ============================================================================
// Module : ew_ddr_sched
// Brief  : Queues finished event windows and launches one DDR transfer at a
//          time, advancing a wrapping DDR ring address. Optional WAIT watchdog
//          enabled by defining EW_DDR_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ew_ddr_sched
  import ew_ddr_sched_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [31:0] DDR_WRAP_BEATS = 32'h0100_0000
) (
  input  logic                   serdesclk,
  input  logic                   resetn_serdesclk,
  input  logic                   ew_done,
  input  logic                   curr_ewfifo_wr,
  input  logic [c_size_bits-1:0] ew_size,
  input  logic [c_tag_bits-1:0]  ew_tag,
  input  logic                   ew_ovfl,
  input  logic                   ddr_done,
  output logic                   axi_start_on_serdesclk,
  output logic                   ewfifo_rd_sel,
  output logic [c_size_bits-1:0] xfer_size,
  output logic [c_tag_bits-1:0]  xfer_tag,
  output logic                   xfer_ovfl,
  output logic [31:0]            ddr_wr_addr,
  output logic                   sched_busy,
  output logic                   queue_full,
  output logic [15:0]            drop_cnt,
  output logic                   timeout_err
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_timeout;
  ew_desc_t     w_push_desc;
  ew_desc_t     w_head;

  logic                   r_axi_start;
  logic                   r_rd_sel;
  logic [c_size_bits-1:0] r_xfer_size;
  logic [c_tag_bits-1:0]  r_xfer_tag;
  logic                   r_xfer_ovfl;
  logic [31:0]            r_ddr_wr_addr;
  logic                   r_sched_busy;
  logic [15:0]            r_drop_cnt;

  logic [32:0] w_size_mod;
  logic [32:0] w_addr_sum;
  logic [31:0] w_addr_nxt;

  assign w_push_desc = '{sel: curr_ewfifo_wr, size: ew_size, tag: ew_tag, ovfl: ew_ovfl};

  ew_desc_fifo u_desc_fifo (
    .serdesclk        (serdesclk),
    .resetn_serdesclk (resetn_serdesclk),
    .push             (ew_done),
    .push_data        (w_push_desc),
    .pop              (w_pop),
    .pop_data         (w_head),
    .full             (w_full),
    .empty            (w_empty)
  );

  always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
    if (!resetn_serdesclk) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:    if (!w_empty) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT:    if (ddr_done || w_timeout) w_state_nxt = ST_ADVANCE;
      ST_ADVANCE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Reducing the size first keeps both addends below the ring size, so one
  // conditional subtract on the 33-bit sum yields the exact modulo.
  assign w_size_mod = 33'(r_xfer_size) % {1'b0, DDR_WRAP_BEATS};
  assign w_addr_sum = {1'b0, r_ddr_wr_addr} + w_size_mod;
  assign w_addr_nxt = 32'((w_addr_sum >= {1'b0, DDR_WRAP_BEATS}) ?
                          (w_addr_sum - {1'b0, DDR_WRAP_BEATS}) : w_addr_sum);

  always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
    if (!resetn_serdesclk) begin
      r_axi_start   <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_xfer_size   <= '0;
      r_xfer_tag    <= '0;
      r_xfer_ovfl   <= 1'b0;
      r_ddr_wr_addr <= 32'd0;
      r_sched_busy  <= 1'b0;
      r_drop_cnt    <= 16'd0;
    end else begin
      r_axi_start <= (r_state == ST_LOAD);
      if (r_state == ST_LOAD) begin
        r_rd_sel     <= w_head.sel;
        r_xfer_size  <= w_head.size;
        r_xfer_tag   <= w_head.tag;
        r_xfer_ovfl  <= w_head.ovfl;
        r_sched_busy <= 1'b1;
      end
      if (r_state == ST_ADVANCE) begin
        r_ddr_wr_addr <= w_addr_nxt;
        r_sched_busy  <= 1'b0;
      end
      if (ew_done && w_full && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

`ifdef EW_DDR_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  assign w_timeout = (r_state == ST_WAIT) && !ddr_done &&
                     (r_wait_cnt == (TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge serdesclk or negedge resetn_serdesclk) begin
    if (!resetn_serdesclk) begin
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout_cycles;

  assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign w_timeout               = 1'b0;
  assign timeout_err             = 1'b0;
`endif

  assign axi_start_on_serdesclk = r_axi_start;
  assign ewfifo_rd_sel          = r_rd_sel;
  assign xfer_size              = r_xfer_size;
  assign xfer_tag               = r_xfer_tag;
  assign xfer_ovfl              = r_xfer_ovfl;
  assign ddr_wr_addr            = r_ddr_wr_addr;
  assign sched_busy             = r_sched_busy;
  assign queue_full             = w_full;
  assign drop_cnt               = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ew_ddr_sched.sv
// ============================================================================
// Module : tb_ew_ddr_sched
// Brief  : Scoreboard bench for ew_ddr_sched on a 32-beat DDR ring; the
//          watchdog scenario is built when EW_DDR_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ew_ddr_sched;
  import ew_ddr_sched_pkg::*;

  localparam logic [31:0] c_wrap = 32'd32;

  logic                   serdesclk = 1'b0;
  logic                   resetn_serdesclk = 1'b0;
  logic                   ew_done = 1'b0;
  logic                   curr_ewfifo_wr = 1'b0;
  logic [c_size_bits-1:0] ew_size = '0;
  logic [c_tag_bits-1:0]  ew_tag = '0;
  logic                   ew_ovfl = 1'b0;
  logic                   ddr_done = 1'b0;
  logic                   axi_start_on_serdesclk;
  logic                   ewfifo_rd_sel;
  logic [c_size_bits-1:0] xfer_size;
  logic [c_tag_bits-1:0]  xfer_tag;
  logic                   xfer_ovfl;
  logic [31:0]            ddr_wr_addr;
  logic                   sched_busy;
  logic                   queue_full;
  logic [15:0]            drop_cnt;
  logic                   timeout_err;

  ew_ddr_sched #(
    .TIMEOUT_CYCLES (16'd100),
    .DDR_WRAP_BEATS (c_wrap)
  ) u_dut (
    .serdesclk              (serdesclk),
    .resetn_serdesclk       (resetn_serdesclk),
    .ew_done                (ew_done),
    .curr_ewfifo_wr         (curr_ewfifo_wr),
    .ew_size                (ew_size),
    .ew_tag                 (ew_tag),
    .ew_ovfl                (ew_ovfl),
    .ddr_done               (ddr_done),
    .axi_start_on_serdesclk (axi_start_on_serdesclk),
    .ewfifo_rd_sel          (ewfifo_rd_sel),
    .xfer_size              (xfer_size),
    .xfer_tag               (xfer_tag),
    .xfer_ovfl              (xfer_ovfl),
    .ddr_wr_addr            (ddr_wr_addr),
    .sched_busy             (sched_busy),
    .queue_full             (queue_full),
    .drop_cnt               (drop_cnt),
    .timeout_err            (timeout_err)
  );

  always #3 serdesclk = ~serdesclk;

  typedef struct {
    logic                   sel;
    logic [c_size_bits-1:0] size;
    logic [c_tag_bits-1:0]  tag;
    logic                   ovfl;
  } exp_t;

  exp_t                   sb[$];
  int                     n_vec = 0;
  int                     n_err = 0;
  logic [31:0]            exp_addr = 32'd0;
  logic [15:0]            exp_drop = 16'd0;
  logic [c_size_bits-1:0] last_size = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Every launched transfer must match the oldest accepted window.
  always @(negedge serdesclk) begin : p_mon
    exp_t e;
    if (resetn_serdesclk && axi_start_on_serdesclk) begin
      if (sb.size() == 0) begin
        check_val("unexpected_start", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_val("start_rd_sel", ewfifo_rd_sel, e.sel);
        check_val("start_size",   xfer_size,     e.size);
        check_val("start_tag",    xfer_tag,      e.tag);
        check_val("start_ovfl",   xfer_ovfl,     e.ovfl);
        check_val("start_addr",   ddr_wr_addr,   exp_addr);
        last_size = e.size;
      end
    end
  end

  // Called on a falling edge; returns one falling edge later.
  task automatic send(input logic sel, input logic [c_size_bits-1:0] size,
                      input logic [c_tag_bits-1:0] tag, input logic ovfl, input bit accept);
    curr_ewfifo_wr = sel;
    ew_size        = size;
    ew_tag         = tag;
    ew_ovfl        = ovfl;
    ew_done        = 1'b1;
    if (accept) sb.push_back('{sel, size, tag, ovfl});
    else        exp_drop++;
    @(negedge serdesclk);
    ew_done = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!axi_start_on_serdesclk && lat < 50) begin
      @(negedge serdesclk);
      lat++;
    end
    if (lat >= 50) check_val("start_wait_expired", 64'(lat), 64'd0);
  endtask

  // Called on a falling edge inside WAIT.
  task automatic complete();
    ddr_done = 1'b1;
    @(negedge serdesclk);
    ddr_done = 1'b0;
    exp_addr = (exp_addr + 32'(last_size)) % c_wrap;
    @(negedge serdesclk);
    check_val("advance_addr", ddr_wr_addr, exp_addr);
    check_val("advance_busy", sched_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int lat;
    int n;

    repeat (3) @(negedge serdesclk);
    check_val("rst_axi_start", axi_start_on_serdesclk, 1'b0);
    check_val("rst_rd_sel",    ewfifo_rd_sel,          1'b0);
    check_val("rst_size",      xfer_size,              '0);
    check_val("rst_tag",       xfer_tag,               '0);
    check_val("rst_addr",      ddr_wr_addr,            32'd0);
    check_val("rst_busy",      sched_busy,             1'b0);
    check_val("rst_full",      queue_full,             1'b0);
    check_val("rst_drop",      drop_cnt,               16'd0);
    check_val("rst_timeout",   timeout_err,            1'b0);
    resetn_serdesclk = 1'b1;
    @(negedge serdesclk);

    // First window from an idle, empty queue.
    send(1'b1, 16'd16, 20'h00ABC, 1'b0, 1'b1);
    wait_start(lat);
    check_val("start_latency", 64'(lat + 1), 64'd3);
    check_val("busy_in_start", sched_busy, 1'b1);
    @(negedge serdesclk);
    check_val("start_one_cycle", axi_start_on_serdesclk, 1'b0);
    complete();

    // Stray ddr_done while idle.
    ddr_done = 1'b1;
    @(negedge serdesclk);
    ddr_done = 1'b0;
    repeat (4) @(negedge serdesclk);
    check_val("stray_done_addr", ddr_wr_addr, exp_addr);
    check_val("stray_done_busy", sched_busy, 1'b0);

    // Three windows arrive while the first transfer is held in WAIT.
    send(1'b0, 16'd8, 20'h00001, 1'b0, 1'b1);
    wait_start(lat);
    @(negedge serdesclk);
    send(1'b1, 16'd16, 20'h00002, 1'b1, 1'b1);
    send(1'b0, 16'd0,  20'h00003, 1'b0, 1'b1);
    send(1'b1, 16'd5,  20'h00004, 1'b0, 1'b0);
    check_val("queue_full", queue_full, 1'b1);
    check_val("drop_cnt",   drop_cnt,   exp_drop);
    repeat (3) @(negedge serdesclk);
    check_val("held_busy", sched_busy, 1'b1);
    complete();
    wait_start(lat);
    @(negedge serdesclk);
    complete();
    check_val("wrap_addr", ddr_wr_addr, 32'd8);
    wait_start(lat);
    @(negedge serdesclk);
    complete();
    check_val("zero_size_addr", ddr_wr_addr, 32'd8);
    check_val("queue_drained", queue_full, 1'b0);

    // Second window lands on the cycle the first is popped.
    send(1'b0, 16'd4, 20'h00005, 1'b0, 1'b1);
    @(negedge serdesclk);
    send(1'b1, 16'd2, 20'h00006, 1'b1, 1'b1);
    wait_start(lat);
    @(negedge serdesclk);
    check_val("pushpop_not_full", queue_full, 1'b0);
    complete();
    wait_start(lat);
    @(negedge serdesclk);
    complete();

`ifdef EW_DDR_TIMEOUT_EN
    send(1'b0, 16'd3, 20'h00007, 1'b0, 1'b1);
    send(1'b1, 16'd1, 20'h00008, 1'b0, 1'b1);
    wait_start(lat);
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge serdesclk);
      n++;
    end
    check_val("timeout_cycles", 64'(n), 64'd101);
    exp_addr = (exp_addr + 32'(last_size)) % c_wrap;
    @(negedge serdesclk);
    check_val("timeout_addr", ddr_wr_addr, exp_addr);
    wait_start(lat);
    @(negedge serdesclk);
    complete();
    check_val("timeout_sticky", timeout_err, 1'b1);
`else
    n = 0;
    check_val("timeout_tied", timeout_err, 1'b0);
`endif

    // Reset asserted mid-transfer.
    send(1'b1, 16'd4, 20'h00009, 1'b1, 1'b1);
    wait_start(lat);
    @(negedge serdesclk);
    #1 resetn_serdesclk = 1'b0;
    #1;
    check_val("arst_busy",    sched_busy,    1'b0);
    check_val("arst_addr",    ddr_wr_addr,   32'd0);
    check_val("arst_rd_sel",  ewfifo_rd_sel, 1'b0);
    check_val("arst_size",    xfer_size,     '0);
    check_val("arst_ovfl",    xfer_ovfl,     1'b0);
    check_val("arst_drop",    drop_cnt,      16'd0);
    check_val("arst_timeout", timeout_err,   1'b0);
    sb.delete();
    exp_addr = 32'd0;
    exp_drop = 16'd0;
    @(negedge serdesclk);
    @(negedge serdesclk);
    resetn_serdesclk = 1'b1;
    @(negedge serdesclk);
    send(1'b0, 16'd7, 20'h0000A, 1'b1, 1'b1);
    wait_start(lat);
    check_val("post_rst_latency", 64'(lat + 1), 64'd3);
    @(negedge serdesclk);
    complete();

    check_val("sb_empty",   64'(sb.size()), 64'd0);
    check_val("final_drop", drop_cnt, exp_drop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
